incr_stream_checker: RTL
========================

Name: incr_stream_checker

Overview:
- Receive-side consumer for the incrementing datapath (in + 1 per sample, small/quad/wide lanes).
- Accepts a valid-qualified stream of WIDTH-bit words and locks onto it.
- Checks that each accepted word equals the previous expected word + 1, modulo 2^WIDTH.
- Reports lock state, saturating match/error counts and a first-error snapshot; sits at the sink end of the wide lane in simulation/top-level self-check builds.

Parameters:
- WIDTH, 70, data word width in bits (must be ≥ 2).
- CNT_W, 16, width of match_count and err_count.
- LOST_THRESH, 3, consecutive mismatches in LOCKED that force re-acquisition (≥ 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  checker enable; 0 forces IDLE.
- clear  input  1  synchronous clear of counters and error snapshot; state and lock are unaffected.
- in_valid  input  1  data beat qualifier; no backpressure, so every cycle with in_valid=1 and state≠IDLE is an accepted beat.
- in_data  input  WIDTH  data word.
- locked  output  1  high while state=LOCKED.
- match_count  output  CNT_W  saturating count of matching beats.
- err_count  output  CNT_W  saturating count of mismatching beats.
- err_seen  output  1  sticky: at least one mismatch since reset/clear.
- first_err_exp  output  WIDTH  expected value at the first mismatch.
- first_err_act  output  WIDTH  received value at the first mismatch.

Behaviour:
- Reset: on reset=1 at clk edge:
  - state=IDLE, expected=0, miss_run=0.
  - All outputs 0.
  - Reset has priority over clear, enable and in_valid; a beat present during reset is ignored.
- All outputs are registered and reflect an accepted beat one cycle after the accepting edge.
- FSM transitions:
  - IDLE: enable=1 → ACQUIRE next cycle. Beats arriving while in IDLE are ignored.
  - ACQUIRE: on an accepted beat, expected ← in_data+1 (mod 2^WIDTH), miss_run←0, go to LOCKED. This acquisition beat counts as neither a match nor an error.
  - LOCKED, accepted beat with in_data==expected:
    - match_count++ (saturating at 2^CNT_W−1), miss_run←0, expected←expected+1.
  - LOCKED, accepted beat with in_data≠expected:
    - err_count++ (saturating), expected←expected+1; the reference sequence is kept and does not resync to the bad word.
    - miss_run++.
    - If miss_run reaches LOST_THRESH: go to ACQUIRE, miss_run←0.
  - Any state, enable=0 → IDLE next cycle. Counters and snapshot hold; locked=0.
- First-error snapshot: on a mismatch while err_seen=0, capture first_err_exp/first_err_act and set err_seen. Later mismatches do not overwrite the snapshot.
- Wrap-around: all-ones followed by 0 is a match; expected arithmetic is WIDTH bits with the carry discarded.
- clear=1 together with an accepted beat: clear wins for counters and snapshot (all zero after the edge); the FSM and expected still update from the beat.
- Counter saturation: once at max, a counter holds. Saturation of one counter does not affect the other.
- No in_valid: state, expected and miss_run hold.

Test Plan:
- Basic lock, WIDTH=70: reset, enable, feed 0..9 back-to-back → locked=1 from the cycle after beat 0; final match_count=9, err_count=0, err_seen=0.
- Wrap: lock on 2^70−3, then feed 2^70−2, 2^70−1, 0, 1 → match_count=4, err_count=0, locked stays 1.
- Single corruption: feed 5,6,99,8,9 → match_count=3, err_count=1, err_seen=1, first_err_exp=7, first_err_act=99, locked stays 1; then feed 10 with clear=1 → counters and snapshot 0, locked=1.
- Loss and re-acquire, LOST_THRESH=3: feed 10,50,60,70 → err_count=3, locked=0 the cycle after 70; feed 200,201 → locked=1 after 200, match_count=1, snapshot still exp=11, act=50.
- Reset mid-stream: locked after 0..4, assert reset for 1 cycle with in_valid=1, in_data=5 → all outputs 0 next cycle, state IDLE; beat 5 ignored.
- Saturation, CNT_W=4: lock on 0, feed 1..20 → match_count=15; then feed 40 → err_count=1, match_count stays 15.

Source files
------------

// File: rtl/incr_stream_checker.sv
// Sink-side checker for an incrementing data stream: locks onto the first accepted word,
// then expects each later word to be the previous one + 1 and keeps match/error statistics.
module incr_stream_checker #(
    parameter int WIDTH       = 70,
    parameter int CNT_W       = 16,
    parameter int LOST_THRESH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             locked,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_seen,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_act
);

    localparam int MISS_W = (LOST_THRESH < 2) ? 1 : $clog2(LOST_THRESH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    expected_q, expected_d;
    logic [MISS_W-1:0]   miss_run_q, miss_run_d;
    logic                locked_q, locked_d;
    logic [CNT_W-1:0]    match_q, match_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic                err_seen_q, err_seen_d;
    logic [WIDTH-1:0]    first_exp_q, first_exp_d;
    logic [WIDTH-1:0]    first_act_q, first_act_d;

    logic                accept;
    logic                is_match;

    assign accept   = in_valid && enable && (state_q != IDLE);
    assign is_match = (in_data == expected_q);

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        miss_run_d  = miss_run_q;
        match_d     = match_q;
        err_d       = err_q;
        err_seen_d  = err_seen_q;
        first_exp_d = first_exp_q;
        first_act_d = first_act_q;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    if (accept) begin
                        expected_d = in_data + WIDTH'(1);
                        miss_run_d = '0;
                        state_d    = LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        // The reference sequence advances on every beat, good or bad.
                        expected_d = expected_q + WIDTH'(1);
                        if (is_match) begin
                            miss_run_d = '0;
                            if (match_q != '1) match_d = match_q + CNT_W'(1);
                        end else begin
                            if (err_q != '1) err_d = err_q + CNT_W'(1);
                            if (!err_seen_q) begin
                                err_seen_d  = 1'b1;
                                first_exp_d = expected_q;
                                first_act_d = in_data;
                            end
                            if (miss_run_q == MISS_W'(LOST_THRESH - 1)) begin
                                miss_run_d = '0;
                                state_d    = ACQUIRE;
                            end else begin
                                miss_run_d = miss_run_q + MISS_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Clear only touches statistics; the lock state keeps tracking the stream.
        if (clear) begin
            match_d     = '0;
            err_d       = '0;
            err_seen_d  = 1'b0;
            first_exp_d = '0;
            first_act_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            expected_q  <= '0;
            miss_run_q  <= '0;
            locked_q    <= 1'b0;
            match_q     <= '0;
            err_q       <= '0;
            err_seen_q  <= 1'b0;
            first_exp_q <= '0;
            first_act_q <= '0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            miss_run_q  <= miss_run_d;
            locked_q    <= locked_d;
            match_q     <= match_d;
            err_q       <= err_d;
            err_seen_q  <= err_seen_d;
            first_exp_q <= first_exp_d;
            first_act_q <= first_act_d;
        end
    end

    assign locked        = locked_q;
    assign match_count   = match_q;
    assign err_count     = err_q;
    assign err_seen      = err_seen_q;
    assign first_err_exp = first_exp_q;
    assign first_err_act = first_act_q;

endmodule
